// File: rtl/adder_tree_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_seq
// Description : Multi-beat signed reduction that reuses one adder tree and
//               accumulates each beat's sum. Option: ADDER_TREE_SEQ_PIPE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_seq #(
    parameter int INPUT_BW   = 8,
    parameter int LAYER_NUM  = 3,
    parameter int ARRAY_SIZE = 8,
    parameter int BEATS_BW   = 8,
    parameter int ACC_BW     = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BEATS_BW-1:0]        cfg_beats,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [INPUT_BW-1:0] in_data [ARRAY_SIZE],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_BW-1:0]   out_sum,
    output logic                       out_ovf
);

    localparam int SUM_BW = INPUT_BW + LAYER_NUM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef ADDER_TREE_SEQ_PIPE_EN
        DRAIN = 2'd3,
`endif
        DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BEATS_BW-1:0]       r_remaining;
    logic signed [ACC_BW-1:0]  r_acc;
    logic                      r_ovf;
    logic                      w_job_start;
    logic                      w_accept;
    logic signed [SUM_BW-1:0]  w_tree_sum;
    logic signed [ACC_BW-1:0]  w_addend;
    logic signed [ACC_BW-1:0]  w_acc_sum;
    logic                      w_add_en;
    logic                      w_add_ovf;

    // Pairwise reduction, halving the live node count per layer; every node is
    // carried at the final width so no layer can overflow.
    function automatic logic signed [SUM_BW-1:0] tree_sum(
        input logic signed [INPUT_BW-1:0] d [ARRAY_SIZE]
    );
        logic signed [SUM_BW-1:0] node [ARRAY_SIZE];
        for (int n = 0; n < ARRAY_SIZE; n++) begin
            node[n] = SUM_BW'(d[n]);
        end
        for (int l = 0; l < LAYER_NUM; l++) begin
            for (int n = 0; n < (ARRAY_SIZE >> (l + 1)); n++) begin
                node[n] = node[2*n] + node[2*n+1];
            end
        end
        return node[0];
    endfunction

    assign w_tree_sum = tree_sum(in_data);
    assign w_accept   = in_ready && in_valid;

`ifdef ADDER_TREE_SEQ_PIPE_EN
    logic signed [SUM_BW-1:0] r_pipe_sum;
    logic                     r_pipe_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_sum <= '0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe_sum <= w_accept ? w_tree_sum : '0;
            r_pipe_vld <= w_accept;
        end
    end

    assign w_addend = ACC_BW'(r_pipe_sum);
    assign w_add_en = r_pipe_vld;
`else
    assign w_addend = ACC_BW'(w_tree_sum);
    assign w_add_en = w_accept;
`endif

    assign w_acc_sum = r_acc + w_addend;
    assign w_add_ovf = (r_acc[ACC_BW-1] == w_addend[ACC_BW-1]) &&
                       (w_acc_sum[ACC_BW-1] != r_acc[ACC_BW-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_job_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_job_start = 1'b1;
                    w_state_nxt = (cfg_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == BEATS_BW'(1))) begin
`ifdef ADDER_TREE_SEQ_PIPE_EN
                    w_state_nxt = DRAIN;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef ADDER_TREE_SEQ_PIPE_EN
            DRAIN: begin
                w_state_nxt = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else if (w_job_start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= cfg_beats;
        end else begin
            if (w_add_en) begin
                r_acc <= w_acc_sum;
                if (w_add_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_accept) begin
                r_remaining <= r_remaining - BEATS_BW'(1);
            end
        end
    end

    assign out_sum = r_acc;
    assign out_ovf = r_ovf;

endmodule
`default_nettype wire
